// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers processor reads/writes through a
// DataDone handshake with a fixed per-access wait, plus a preload port and
// sticky address / protocol error flags.
module data_mem_responder #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    input  logic                 InitWrite,
    input  logic [WORD_SIZE-1:0] InitAddr,
    input  logic [WORD_SIZE-1:0] InitData,
    output logic                 AddrErr,
    output logic                 ProtoErr
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned XW = WORD_SIZE + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WORD_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_data;
    logic                 lat_rd;
    logic                 lat_wr;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic                 req_c;
    logic                 accept_c;
    logic                 commit_c;
    logic [WORD_SIZE-1:0] c_addr;
    logic [WORD_SIZE-1:0] c_data;
    logic                 c_write;
    logic                 c_in_range;
    logic                 init_in_range;
    logic                 mismatch_c;
    logic [IW-1:0]        c_idx;

    // Handshake only drops while an access is waiting out its latency.
    assign DataDone = (state != WAIT);

    // Accept/commit decode; with zero latency the live inputs commit directly.
    always_comb begin
        req_c         = ReadData | WriteData;
        accept_c      = (state != WAIT) && req_c;
        commit_c      = 1'b0;
        c_addr        = lat_addr;
        c_data        = lat_data;
        c_write       = lat_wr & ~lat_rd;
        if (LATENCY == 0) begin
            commit_c = accept_c;
            c_addr   = DataAddr;
            c_data   = DataOut;
            c_write  = WriteData & ~ReadData;
        end else begin
            commit_c = (state == WAIT) && (cnt == CW'(1));
        end
        c_in_range    = XW'(c_addr) < XW'(DEPTH);
        init_in_range = XW'(InitAddr) < XW'(DEPTH);
        c_idx         = c_addr[IW-1:0];
        mismatch_c    = req_c && ((ReadData != lat_rd) || (WriteData != lat_wr) ||
                                  (DataAddr != lat_addr) ||
                                  (lat_wr && !lat_rd && (DataOut != lat_data)));
    end

    // Handshake FSM, request latch, read data and sticky error flags.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            DataIn   <= '0;
            AddrErr  <= 1'b0;
            ProtoErr <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        lat_addr <= DataAddr;
                        lat_data <= DataOut;
                        lat_rd   <= ReadData;
                        lat_wr   <= WriteData;
                        if (ReadData && WriteData) ProtoErr <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (mismatch_c) ProtoErr <= 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit_c) begin
                if (!c_in_range) AddrErr <= 1'b1;
                if (!c_write) DataIn <= c_in_range ? mem[c_idx] : '0;
            end
        end
    end

    // Memory array: preload first so a same-edge write commit overrides it.
    always_ff @(posedge Clock) begin
        if (InitWrite && init_in_range) mem[InitAddr[IW-1:0]] <= InitData;
        if (commit_c && c_write && c_in_range && !Reset) mem[c_idx] <= c_data;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one LATENCY=2 and one LATENCY=0 responder sharing stimulus.
module tb_data_mem_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataAddr, DataOut, InitAddr, InitData;
    logic        ReadData, WriteData, InitWrite;
    logic [15:0] din2, din0;
    logic        done2, done0, aerr2, aerr0, perr2, perr0;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(2)) u_lat2 (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(din2), .DataDone(done2),
        .InitWrite(InitWrite), .InitAddr(InitAddr), .InitData(InitData),
        .AddrErr(aerr2), .ProtoErr(perr2)
    );

    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(0)) u_lat0 (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(din0), .DataDone(done0),
        .InitWrite(InitWrite), .InitAddr(InitAddr), .InitData(InitData),
        .AddrErr(aerr0), .ProtoErr(perr0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        InitWrite = 1'b1; InitAddr = a; InitData = d;
        tick();
        InitWrite = 1'b0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        ReadData = rd; WriteData = wr; DataAddr = a; DataOut = d;
    endtask

    task automatic idle_req();
        req(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        Reset = 1'b1;
        idle_req();
        InitWrite = 1'b0; InitAddr = '0; InitData = '0;
        #12;
        check("rst_done", 32'(done2), 32'd1);
        check("rst_din", 32'(din2), 32'h0);
        check("rst_aerr", 32'(aerr2), 32'd0);
        check("rst_perr", 32'(perr2), 32'd0);
        check("rst_done0", 32'(done0), 32'd1);
        @(negedge Clock);
        Reset = 1'b0;
        tick();

        // basic read with two wait cycles
        preload(16'd5, 16'h1234);
        req(1'b1, 1'b0, 16'd5, 16'h0);
        tick(); check("rd5_wait1", 32'(done2), 32'd0);
        tick(); check("rd5_wait2", 32'(done2), 32'd0);
        tick(); check("rd5_done", 32'(done2), 32'd1);
        check("rd5_data", 32'(din2), 32'h1234);
        idle_req();
        tick();

        // write then back-to-back read from the DONE cycle
        req(1'b0, 1'b1, 16'd9, 16'hBEEF);
        tick(); check("wr9_wait", 32'(done2), 32'd0);
        tick();
        tick(); check("wr9_done", 32'(done2), 32'd1);
        check("wr9_din_held", 32'(din2), 32'h1234);
        req(1'b1, 1'b0, 16'd9, 16'h0);
        tick(); check("b2b_accept", 32'(done2), 32'd0);
        tick();
        tick(); check("rd9_done", 32'(done2), 32'd1);
        check("rd9_data", 32'(din2), 32'hBEEF);
        check("rd9_perr", 32'(perr2), 32'd0);
        check("rd9_aerr", 32'(aerr2), 32'd0);

        // out-of-range read, then a valid read back-to-back
        req(1'b1, 1'b0, 16'd300, 16'h0);
        tick(); check("rd300_wait", 32'(done2), 32'd0);
        tick();
        tick(); check("rd300_done", 32'(done2), 32'd1);
        check("rd300_data", 32'(din2), 32'h0);
        check("rd300_aerr", 32'(aerr2), 32'd1);
        req(1'b1, 1'b0, 16'd9, 16'h0);
        tick(); tick(); tick();
        check("rd9b_data", 32'(din2), 32'hBEEF);
        check("aerr_sticky", 32'(aerr2), 32'd1);
        idle_req();
        tick();

        // address changes mid-wait: flag raised, original address used
        req(1'b1, 1'b0, 16'd5, 16'h0);
        tick();
        DataAddr = 16'd9;
        tick(); check("midwait_perr", 32'(perr2), 32'd1);
        tick(); check("midwait_data", 32'(din2), 32'h1234);
        idle_req();
        tick();

        // preload colliding with a write commit: commit data wins
        req(1'b0, 1'b1, 16'd20, 16'h1111);
        tick(); tick();
        InitWrite = 1'b1; InitAddr = 16'd20; InitData = 16'h2222;
        tick();
        InitWrite = 1'b0;
        req(1'b1, 1'b0, 16'd20, 16'h0);
        tick(); tick(); tick();
        check("collide_data", 32'(din2), 32'h1111);
        idle_req();
        tick();

        // reset mid-wait of a write abandons it
        @(negedge Clock); Reset = 1'b1; #1;
        check("rst2_perr", 32'(perr2), 32'd0);
        check("rst2_aerr", 32'(aerr2), 32'd0);
        @(negedge Clock); Reset = 1'b0;
        tick();
        preload(16'd7, 16'h7777);
        req(1'b0, 1'b1, 16'd7, 16'hAAAA);
        tick(); check("wr7_wait", 32'(done2), 32'd0);
        Reset = 1'b1; #1;
        check("wr7_rst_done", 32'(done2), 32'd1);
        check("wr7_rst_din", 32'(din2), 32'h0);
        check("wr7_rst_perr", 32'(perr2), 32'd0);
        idle_req();
        @(negedge Clock); Reset = 1'b0;
        tick();
        req(1'b1, 1'b0, 16'd7, 16'h0);
        tick(); tick(); tick();
        check("rd7_unchanged", 32'(din2), 32'h7777);

        // read and write together: read performed, flag raised
        req(1'b1, 1'b1, 16'd5, 16'h5555);
        tick(); tick(); tick();
        check("both_data", 32'(din2), 32'h1234);
        check("both_perr", 32'(perr2), 32'd1);
        req(1'b1, 1'b0, 16'd5, 16'h0);
        tick(); tick(); tick();
        check("both_nowrite", 32'(din2), 32'h1234);
        idle_req();
        tick();

        // zero-latency instance: alternating writes and reads every cycle
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock); Reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b1, 16'(i), 16'hA000 + 16'(i));
            tick(); check("l0_wr_done", 32'(done0), 32'd1);
            req(1'b1, 1'b0, 16'(i), 16'h0);
            tick(); check("l0_rd_done", 32'(done0), 32'd1);
            check("l0_rd_data", 32'(din0), 32'hA000 + 32'(i));
        end
        check("l0_perr", 32'(perr0), 32'd0);
        idle_req();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
